// File: rtl/exec_cc_stage.sv
// Y86 execute-stage back end: condition-code register, branch/cmov condition
// evaluation, and the E->M pipeline latch with stall/bubble control.
module exec_cc_stage #(
   parameter int         WIDTH    = 64,
   parameter logic [3:0] RNONE    = 4'hF,
   parameter logic [2:0] CC_RESET = 3'b100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       e_icode,
   input  logic [3:0]       e_ifun,
   input  logic [3:0]       e_stat,
   input  logic [WIDTH-1:0] alu_ans,
   input  logic             alu_ovf,
   input  logic [WIDTH-1:0] e_valA,
   input  logic [3:0]       e_dstE,
   input  logic [3:0]       e_dstM,
   input  logic             m_exc,
   input  logic             W_exc,
   input  logic             M_stall,
   input  logic             M_bubble,
   output logic [2:0]       cc,
   output logic             e_cnd,
   output logic [3:0]       e_dstE_out,
   output logic [3:0]       M_icode,
   output logic             M_cnd,
   output logic [WIDTH-1:0] M_valE,
   output logic [WIDTH-1:0] M_valA,
   output logic [3:0]       M_dstE,
   output logic [3:0]       M_dstM,
   output logic [3:0]       M_stat
);

   localparam logic [3:0] I_NOP  = 4'h1;
   localparam logic [3:0] I_CMOV = 4'h2;
   localparam logic [3:0] I_OPQ  = 4'h6;
   localparam logic [3:0] S_AOK  = 4'h1;

   logic zf, sf, of;
   logic set_cc;

   assign zf = cc[2];
   assign sf = cc[1];
   assign of = cc[0];

   // Any exception already in M or W freezes the flags so squashed work cannot change them.
   assign set_cc = (e_icode == I_OPQ) && !m_exc && !W_exc && (e_stat == S_AOK);

   always_comb begin
      e_cnd = 1'b0;
      case (e_ifun)
         4'h0:    e_cnd = 1'b1;
         4'h1:    e_cnd = (sf ^ of) | zf;
         4'h2:    e_cnd = sf ^ of;
         4'h3:    e_cnd = zf;
         4'h4:    e_cnd = ~zf;
         4'h5:    e_cnd = ~(sf ^ of);
         4'h6:    e_cnd = ~(sf ^ of) & ~zf;
         default: e_cnd = 1'b0;
      endcase
   end

   assign e_dstE_out = ((e_icode == I_CMOV) && !e_cnd) ? RNONE : e_dstE;

   always_ff @(posedge clk) begin
      if (rst) begin
         cc <= CC_RESET;
      end else if (set_cc) begin
         cc <= {(alu_ans == '0), alu_ans[WIDTH-1], alu_ovf};
      end
   end

   // Control contract: M_stall holds every field; M_bubble inserts a nop; stall beats bubble.
   always_ff @(posedge clk) begin
      if (rst || (M_bubble && !M_stall)) begin
         M_icode <= I_NOP;
         M_cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
         M_stat  <= S_AOK;
      end else if (!M_stall) begin
         M_icode <= e_icode;
         M_cnd   <= e_cnd;
         M_valE  <= alu_ans;
         M_valA  <= e_valA;
         M_dstE  <= e_dstE_out;
         M_dstM  <= e_dstM;
         M_stat  <= e_stat;
      end
   end

endmodule

// File: tb/tb_exec_cc_stage.sv
// Directed bench for exec_cc_stage: the driver pushes hand-computed expectations
// into a queue tagged with the cycle they are due; the monitor pops and compares.
module tb_exec_cc_stage;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    e_icode, e_ifun, e_stat, e_dstE, e_dstM;
   logic [W-1:0]  alu_ans, e_valA;
   logic          alu_ovf, m_exc, W_exc, M_stall, M_bubble;
   logic [2:0]    cc;
   logic          e_cnd;
   logic [3:0]    e_dstE_out, M_icode, M_dstE, M_dstM, M_stat;
   logic          M_cnd;
   logic [W-1:0]  M_valE, M_valA;

   exec_cc_stage #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .e_icode(e_icode), .e_ifun(e_ifun), .e_stat(e_stat),
      .alu_ans(alu_ans), .alu_ovf(alu_ovf), .e_valA(e_valA), .e_dstE(e_dstE),
      .e_dstM(e_dstM), .m_exc(m_exc), .W_exc(W_exc), .M_stall(M_stall),
      .M_bubble(M_bubble), .cc(cc), .e_cnd(e_cnd), .e_dstE_out(e_dstE_out),
      .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      bit         kind;     // 0: combinational view, 1: M latch
      logic [2:0] cc;
      logic       cnd;
      logic [3:0] dste;
      logic [3:0] icode;
      logic       mcnd;
      logic [W-1:0] vale;
      logic [W-1:0] vala;
      logic [3:0] mdste;
      logic [3:0] mdstm;
      logic [3:0] stat;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_m;
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            if (e.kind == 1'b0) begin
               check("cc", W'(cc), W'(e.cc));
               check("e_cnd", W'(e_cnd), W'(e.cnd));
               check("e_dstE_out", W'(e_dstE_out), W'(e.dste));
            end else begin
               check("M_icode", W'(M_icode), W'(e.icode));
               check("M_cnd", W'(M_cnd), W'(e.mcnd));
               check("M_valE", M_valE, e.vale);
               check("M_valA", M_valA, e.vala);
               check("M_dstE", W'(M_dstE), W'(e.mdste));
               check("M_dstM", W'(M_dstM), W'(e.mdstm));
               check("M_stat", W'(M_stat), W'(e.stat));
            end
         end
      end
   end

   // driver: one vector per cycle, expectations computed by hand in the table below
   task automatic vec(input logic r, input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [3:0] stat, input logic [W-1:0] ans, input logic ovf,
                      input logic [W-1:0] vala, input logic [3:0] dste, input logic [3:0] dstm,
                      input logic mexc, input logic wexc, input logic stall, input logic bub,
                      input bit chk, input logic [2:0] x_cc, input logic x_cnd,
                      input logic [3:0] x_dste);
      exp_t c, m;
      @(posedge clk);
      #1;
      rst = r; e_icode = icode; e_ifun = ifun; e_stat = stat; alu_ans = ans;
      alu_ovf = ovf; e_valA = vala; e_dstE = dste; e_dstM = dstm;
      m_exc = mexc; W_exc = wexc; M_stall = stall; M_bubble = bub;
      if (chk) begin
         c = '{due: cyc, kind: 1'b0, cc: x_cc, cnd: x_cnd, dste: x_dste,
               icode: 4'h0, mcnd: 1'b0, vale: '0, vala: '0, mdste: 4'h0, mdstm: 4'h0, stat: 4'h0};
         exp_q.push_back(c);
      end
      if (r || (bub && !stall)) begin
         m = '{due: 0, kind: 1'b1, cc: 3'b0, cnd: 1'b0, dste: 4'h0,
               icode: 4'h1, mcnd: 1'b0, vale: '0, vala: '0, mdste: 4'hF, mdstm: 4'hF, stat: 4'h1};
      end else if (stall) begin
         m = last_m;
      end else begin
         m = '{due: 0, kind: 1'b1, cc: 3'b0, cnd: 1'b0, dste: 4'h0,
               icode: icode, mcnd: x_cnd, vale: ans, vala: vala, mdste: x_dste, mdstm: dstm, stat: stat};
      end
      m.due = cyc + 1;
      last_m = m;
      exp_q.push_back(m);
   endtask

   localparam logic [W-1:0] MIN_NEG = 64'h8000_0000_0000_0000;

   initial begin
      rst = 1'b0; e_icode = 4'h1; e_ifun = 4'h0; e_stat = 4'h1; alu_ans = '0;
      alu_ovf = 1'b0; e_valA = '0; e_dstE = 4'hF; e_dstM = 4'hF;
      m_exc = 1'b0; W_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
      //   rst icode ifun stat  ans      ovf valA   dstE dstM  mx wx st bb chk  cc      cnd  dstE_out
      vec(1, 4'h1, 4'h0, 4'h1, 64'h0,    0, 64'h0,  4'hF, 4'hF, 0, 0, 0, 0, 0, 3'b000, 0, 4'hF);
      // subq giving zero, then je
      vec(0, 4'h6, 4'h1, 4'h1, 64'h0,    0, 64'h11, 4'h2, 4'hF, 0, 0, 0, 0, 1, 3'b100, 1, 4'h2);
      vec(0, 4'h7, 4'h3, 4'h1, 64'h40,   0, 64'h22, 4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b100, 1, 4'hF);
      // negative with overflow, then sweep conditions
      vec(0, 4'h6, 4'h0, 4'h1, MIN_NEG,  1, 64'h0,  4'h3, 4'hF, 0, 0, 0, 0, 1, 3'b100, 1, 4'h3);
      vec(0, 4'h7, 4'h2, 4'h1, 64'h0,    0, 64'h0,  4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b011, 0, 4'hF);
      vec(0, 4'h7, 4'h5, 4'h1, 64'h0,    0, 64'h0,  4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b011, 1, 4'hF);
      vec(0, 4'h7, 4'h1, 4'h1, 64'h0,    0, 64'h0,  4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b011, 0, 4'hF);
      vec(0, 4'h7, 4'h6, 4'h1, 64'h0,    0, 64'h0,  4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b011, 1, 4'hF);
      vec(0, 4'h7, 4'h3, 4'h1, 64'h0,    0, 64'h0,  4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b011, 0, 4'hF);
      vec(0, 4'h7, 4'h4, 4'h1, 64'h0,    0, 64'h0,  4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b011, 1, 4'hF);
      vec(0, 4'h7, 4'h8, 4'h1, 64'h0,    0, 64'h0,  4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b011, 0, 4'hF);
      // cmovne squashed when ZF=1, taken when ZF=0
      vec(0, 4'h6, 4'h0, 4'h1, 64'h0,    0, 64'h0,  4'h1, 4'hF, 0, 0, 0, 0, 1, 3'b011, 1, 4'h1);
      vec(0, 4'h2, 4'h4, 4'h1, 64'h33,   0, 64'h33, 4'h3, 4'hF, 0, 0, 0, 0, 1, 3'b100, 0, 4'hF);
      vec(0, 4'h6, 4'h0, 4'h1, 64'h5,    0, 64'h0,  4'h1, 4'hF, 0, 0, 0, 0, 1, 3'b100, 1, 4'h1);
      vec(0, 4'h2, 4'h4, 4'h1, 64'h33,   0, 64'h33, 4'h3, 4'hF, 0, 0, 0, 0, 1, 3'b000, 1, 4'h3);
      // exception / bad status blocks the update
      vec(0, 4'h6, 4'h0, 4'h1, 64'h0,    0, 64'h0,  4'h1, 4'hF, 0, 0, 0, 0, 1, 3'b000, 1, 4'h1);
      vec(0, 4'h6, 4'h0, 4'h1, 64'h5,    0, 64'h0,  4'h1, 4'hF, 1, 0, 0, 0, 1, 3'b100, 1, 4'h1);
      vec(0, 4'h6, 4'h0, 4'h1, 64'h5,    0, 64'h0,  4'h1, 4'hF, 0, 1, 0, 0, 1, 3'b100, 1, 4'h1);
      vec(0, 4'h6, 4'h0, 4'h3, 64'h5,    0, 64'h0,  4'h1, 4'hF, 0, 0, 0, 0, 1, 3'b100, 1, 4'h1);
      vec(0, 4'h1, 4'h0, 4'h1, 64'h0,    0, 64'h0,  4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b100, 1, 4'hF);
      // stall/bubble on the M latch
      vec(0, 4'h6, 4'h0, 4'h1, 64'h7,    0, 64'h77, 4'h4, 4'h5, 0, 0, 0, 0, 1, 3'b100, 1, 4'h4);
      vec(0, 4'h7, 4'h0, 4'h1, 64'h99,   0, 64'h88, 4'hF, 4'hF, 0, 0, 1, 1, 1, 3'b000, 1, 4'hF);
      vec(0, 4'h7, 4'h0, 4'h1, 64'h99,   0, 64'h88, 4'hF, 4'hF, 0, 0, 1, 0, 1, 3'b000, 1, 4'hF);
      vec(0, 4'h7, 4'h0, 4'h1, 64'h99,   0, 64'h88, 4'hF, 4'hF, 0, 0, 0, 1, 1, 3'b000, 1, 4'hF);
      // reset with an OPq in E: cc returns to reset value, not the OPq result
      vec(0, 4'h6, 4'h0, 4'h1, 64'h9,    1, 64'h0,  4'h2, 4'hF, 0, 0, 0, 0, 1, 3'b000, 1, 4'h2);
      vec(1, 4'h6, 4'h0, 4'h1, 64'h0,    1, 64'hAB, 4'h2, 4'h3, 0, 0, 1, 0, 1, 3'b001, 1, 4'h2);
      vec(0, 4'h1, 4'h0, 4'h1, 64'h0,    0, 64'h0,  4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b100, 1, 4'hF);

      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
